ex_iter_muldiv: RTL and testbench
=================================

// Module: ex_iter_muldiv
// PURPOSE
//   Parametrised iterative multiply/divide unit beside the EX stage. Executes MULT/MULTU/DIV/DIVU
//   over DATA_W operands and returns a {hi,lo} result. EX holds the instruction and stalls while
//   done is low, then consumes the result into HILO. Supports flush and a held-done/ack handshake.
// PARAMETERS
//   DATA_W   32   operand width; result is 2*DATA_W; must be >= 4
//   CNT_W    6    iteration counter width; must satisfy 2**CNT_W > DATA_W
// PORTS
//   clk          in   1         rising-edge clock
//   rst_n        in   1         asynchronous active-low reset
//   start        in   1         request; sampled only in IDLE
//   op           in   2         00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//   operand_a    in   DATA_W    multiplicand / dividend; sampled with start
//   operand_b    in   DATA_W    multiplier / divisor; sampled with start
//   ack          in   1         EX consumed result; DONE -> IDLE
//   flush        in   1         synchronous cancel of any operation in flight
//   busy         out  1         high in CALC and FIX
//   done         out  1         high in DONE
//   result       out  2*DATA_W  {hi,lo}: product, or {remainder,quotient}
//   div_by_zero  out  1         valid while done; 1 when a DIV/DIVU had operand_b == 0
// BEHAVIOUR
// - Reset (rst_n low, async): state IDLE; busy, done, div_by_zero = 0; result = 0; counter = 0.
// - States: IDLE, CALC, FIX, DONE; state register updates only on clk edges.
// - IDLE: start=1 latches op, |a|, |b| (unsigned ops use raw values) and sign flags.
//   Next state is CALC with counter = 0, or DONE for DIV/DIVU with b == 0.
// - CALC: one bit per cycle for exactly DATA_W cycles, then FIX.
//   - Multiply: shift-add into a 2*DATA_W accumulator.
//   - Divide: restoring shift-subtract, producing the quotient in lo and the remainder in hi.
// - FIX (1 cycle): sign correction, then DONE.
//   - MULT: negate the product when the sign of a differs from the sign of b.
//   - DIV: negate the quotient when the signs differ; the remainder takes the sign of the dividend.
//   - DIV of most-negative by -1 gives quotient = 0x8..0, remainder = 0; no trap.
// - Divide by zero: result = {operand_a, all-ones}, div_by_zero = 1. Applies to DIV and DIVU.
// - DONE: done held high and result stable until ack=1. ack moves DONE -> IDLE at the next edge.
//   - start is ignored in DONE.
//   - A new start is accepted only in IDLE, so back-to-back ops cost at least 1 IDLE cycle.
// - Latency: start high in cycle 0 -> done high from cycle DATA_W+2 (cycle 34 for DATA_W=32).
//   Div-by-zero gives done in cycle 1.
// - start while busy or done: ignored; the latched operands are not disturbed.
// - ack outside DONE: ignored.
// - flush=1: next state IDLE from any state; done and busy low the next cycle.
//   - result and div_by_zero keep their old values.
//   - flush with start in the same cycle: flush wins and the start is dropped.
//   - flush with ack in DONE: IDLE; no distinction is made.
// - result updates only on the FIX->DONE edge and on a div-by-zero entry to DONE.
//   It is otherwise held, including across flush.
// - div_by_zero clears on the edge that accepts the next start.
// CONFIGURATION
// - `define MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle signed/unsigned DATA_W x DATA_W `*`.
//   - The product is registered and the unit goes IDLE -> DONE; done is high in cycle 1.
//   - DIV/DIVU are unchanged.
// - Macro undefined: every op uses the iterative path with latency DATA_W+2.
//   - No `*` operator is inferred.
// TESTING
// - MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done first in cycle 34, result=0xFFFFFFFE_00000001;
//   busy high in cycles 1-33.
// - MULT a=-3 b=7 -> result=0xFFFFFFFF_FFFFFFEB; MULT a=0x80000000 b=0x80000000
//   -> result=0x40000000_00000000.
// - DIV a=-7 b=2 -> hi=0xFFFFFFFF lo=0xFFFFFFFD; DIVU a=100 b=7 -> hi=2 lo=14;
//   DIV a=0x80000000 b=-1 -> hi=0 lo=0x80000000.
// - DIVU a=5 b=0 -> done in cycle 1, div_by_zero=1, result=0x00000005_FFFFFFFF;
//   next start clears div_by_zero.
// - Flush in cycle 10 of a DIVU -> busy=0 and done=0 in cycle 11, result unchanged.
//   A start issued in cycle 3 mid-op is ignored.
// - Hold ack=0 for 5 cycles in DONE -> done and result stable; ack -> IDLE.
//   rst_n low mid-CALC -> all outputs 0 immediately.
//   With MULDIV_FAST_MUL_EN, MULTU 6*7 -> done in cycle 1, result=42.

Source files
------------

// File: rtl/ex_iter_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside EX; returns {hi,lo} with a held-done/ack handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a registered `*` product.
module ex_iter_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     operand_a,
    input  logic [DATA_W-1:0]     operand_b,
    input  logic                  ack,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result,
    output logic                  div_by_zero
);

    localparam int W = DATA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [W-1:0]     m_q, m_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   res_q, res_d;
    logic             dbz_q, dbz_d;

    logic             is_div, sgn, sa, sb, b_zero, fast, last;
    logic [W-1:0]     abs_a, abs_b;
    logic [W:0]       mul_sum, rem_sh, rem_diff;
    logic [2*W-1:0]   mul_step, div_step, fixed, prod;
    logic [W-1:0]     quo, rem;

    assign is_div = op[1];
    assign sgn    = ~op[0];
    assign sa     = sgn & operand_a[W-1];
    assign sb     = sgn & operand_b[W-1];
    assign abs_a  = sa ? -operand_a : operand_a;
    assign abs_b  = sb ? -operand_b : operand_b;
    assign b_zero = is_div && (operand_b == '0);
    assign last   = (cnt_q == CNT_W'(W - 1));

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{W{sa}}, operand_a};
    assign ext_b     = {{W{sb}}, operand_b};
    assign fast_prod = ext_a * ext_b;
    assign fast      = ~is_div;
`else
    assign fast      = 1'b0;
`endif

    // Shift-add: hi accumulates the multiplicand, multiplier bits retire from lo.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]}
                    + (acc_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: remainder in hi, quotient bits enter lo from the right.
    assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign rem_diff = rem_sh - {1'b0, m_q};
    assign div_step = rem_diff[W]
                    ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                    : {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};

    assign prod  = neg_q ? -acc_q : acc_q;
    assign quo   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem   = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    assign fixed = div_q ? {rem, quo} : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) state_d = (b_zero || fast) ? S_DONE : S_CALC;
                S_CALC: if (last) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: if (ack) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_FIX);
        done = (state_q == S_DONE);
    end

    assign result      = res_q;
    assign div_by_zero = dbz_q;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        m_d    = m_q;
        acc_d  = acc_q;
        res_d  = res_q;
        dbz_d  = dbz_q;
        if (!flush) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        div_d  = is_div;
                        neg_d  = sa ^ sb;
                        rneg_d = is_div & sa;
                        cnt_d  = '0;
                        dbz_d  = b_zero;
                        m_d    = is_div ? abs_b : abs_a;
                        acc_d  = is_div ? {{W{1'b0}}, abs_a} : {{W{1'b0}}, abs_b};
                        if (b_zero) res_d = {operand_a, {W{1'b1}}};
`ifdef MULDIV_FAST_MUL_EN
                        if (!is_div) res_d = fast_prod;
`endif
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = div_q ? div_step : mul_step;
                end
                S_FIX:  res_d = fixed;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            m_q    <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            m_q    <= m_d;
            acc_q  <= acc_d;
            res_q  <= res_d;
            dbz_q  <= dbz_d;
        end
    end

endmodule

// File: tb/tb_ex_iter_muldiv.sv
// Randomized and directed bench for ex_iter_muldiv against a plain-arithmetic model.
// Covers latency, busy window, sign rules, div-by-zero, flush, hold/ack and async reset.
module tb_ex_iter_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        ack = 1'b0;
    logic        flush = 1'b0;
    logic        busy, done, div_by_zero;
    logic [63:0] result;

    int errors = 0;
    int checks = 0;
    logic [63:0] last_res = '0;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    ex_iter_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .ack(ack), .flush(flush), .busy(busy), .done(done),
        .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] r, output bit ez);
        longint sa, sb, q, rm;
        longint unsigned ua, ub, uq, urm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ez = 1'b0;
        r = '0;
        case (o)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            default: begin
                if (b == 32'h0) begin
                    ez = 1'b1;
                    r = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    rm = sa % sb;
                    r = {rm[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    urm = ua % ub;
                    r = {urm[31:0], uq[31:0]};
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input int hold);
        logic [63:0] exp;
        bit ez;
        int lat, n, nbusy;
        model(o, a, b, exp, ez);
        lat = ez ? 1 : ((FAST && !o[1]) ? 1 : 34);
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
        n = 1;
        nbusy = 0;
        if (!ez) check("dbz_clr", {63'h0, div_by_zero}, 64'h0);
        while (!done && n < 200) begin
            if (busy) nbusy++;
            if (poke && n == 3) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("busy_cyc", 64'(nbusy), 64'(lat - 1));
        check("result", result, exp);
        check("dbz", {63'h0, div_by_zero}, {63'h0, ez});
        last_res = exp;
        for (int i = 0; i < hold; i++) begin
            start = (i == 1);
            @(posedge clk); #1;
            start = 1'b0;
            check("hold_done", {63'h0, done}, 64'h1);
            check("hold_res", result, exp);
        end
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        check("ack_idle", {63'h0, done}, 64'h0);
    endtask

    initial begin
        logic [63:0] r0;
        bit ez0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_res", result, 64'h0);
        check("rst_dbz", {63'h0, div_by_zero}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r0, ez0);
        check("mdl_multu", r0, 64'hFFFF_FFFE_0000_0001);
        model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r0, ez0);
        check("mdl_div_ovf", r0, 64'h0000_0000_8000_0000);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_op(2'b11, 32'd100, 32'd7, 1'b1, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0, 0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 5);
        run_op(2'b01, 32'd6, 32'd7, 1'b0, 0);
        run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 2);

        // Flush in cycle 10 of a DIVU.
        @(negedge clk);
        start = 1'b1; op = 2'b11; operand_a = 32'd1000; operand_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy", {63'h0, busy}, 64'h0);
        check("fl_done", {63'h0, done}, 64'h0);
        check("fl_res", result, last_res);
        check("fl_dbz", {63'h0, div_by_zero}, 64'h0);

        // Flush and start together: start dropped.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b11; operand_a = 32'd9; operand_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("fs_busy", {63'h0, busy}, 64'h0);
        check("fs_done", {63'h0, done}, 64'h0);
        check("fs_res", result, last_res);

        run_op(2'b11, 32'd100, 32'd7, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            logic [1:0] o;
            logic [31:0] a, b;
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(o, a, b, k[0], k % 3);
        end

        // Async reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; op = 2'b00; operand_a = 32'd12345; operand_b = 32'd678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {63'h0, busy}, 64'h0);
        check("mrst_done", {63'h0, done}, 64'h0);
        check("mrst_res", result, 64'h0);
        check("mrst_dbz", {63'h0, div_by_zero}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
